// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction fetch front end with a DEPTH-entry response queue and redirect flush
// Ports:
//   clk_i, rst_i                          clock, asynchronous active-high reset
//   mem_req_valid_o/ready_i/addr_o        word-aligned fetch requests, one per handshake
//   mem_rsp_valid_i, mem_rsp_data_i       in-order responses, latency >= 1, no backpressure
//   redirect_i, redirect_pc_i             flush queue, drop in-flight responses, restart fetch
//   instr_valid_o/ready_i, instr_o, pc_o  registered queue head towards decode
//   misalign_o                            sticky misaligned-redirect fault (IPQ_MISALIGN_CHK_EN only)
// Optional feature macro: IPQ_MISALIGN_CHK_EN
module instr_prefetch_queue #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_rsp_valid_i,
  input  logic [31:0]     mem_rsp_data_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o
`ifdef IPQ_MISALIGN_CHK_EN
  ,
  output logic            misalign_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  logic [XLEN-1:0] fetch_pc, rsp_pc, tgt;
  logic [CW-1:0] count, inflight, drop, count_rem, inflight_n;
  logic [AW-1:0] rd_ptr, wr_ptr, rd_n;
  logic [31:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc [DEPTH];
  logic halted, req_hs, pop, push, drop_rsp;
  assign tgt = redirect_pc_i & ~XLEN'(3);
  // credits cover both queued and in-flight words, so a response always finds a free slot
  assign mem_req_valid_o = !rst_i && !halted && ({1'b0, count} + {1'b0, inflight} < CAP);
  assign mem_req_addr_o = fetch_pc;
  assign instr_valid_o = count != '0;
  assign req_hs = mem_req_valid_o && mem_req_ready_i;
  assign pop = instr_valid_o && instr_ready_i;
  assign drop_rsp = mem_rsp_valid_i && drop != '0;
  assign push = mem_rsp_valid_i && drop == '0 && !redirect_i;
  assign count_rem = count - CW'(pop);
  assign rd_n = rd_ptr + AW'(pop);
  assign inflight_n = inflight + CW'(req_hs) - CW'(mem_rsp_valid_i);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      count <= '0;
      inflight <= '0;
      drop <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      instr_o <= '0;
      pc_o <= '0;
    end else begin
      inflight <= inflight_n;
      if (redirect_i) begin
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        fetch_pc <= tgt;
        rsp_pc <= tgt;
        drop <= inflight_n;
      end else begin
        count <= count_rem + CW'(push);
        rd_ptr <= rd_n;
        if (req_hs) fetch_pc <= fetch_pc + XLEN'(4);
        if (drop_rsp) drop <= drop - CW'(1);
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          rsp_pc <= rsp_pc + XLEN'(4);
        end
        // head register: next stored entry, or bypass the arriving word into an empty queue
        if (count_rem != '0) begin
          instr_o <= q_instr[rd_n];
          pc_o <= q_pc[rd_n];
        end else if (push) begin
          instr_o <= mem_rsp_data_i;
          pc_o <= rsp_pc;
        end
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_instr[wr_ptr] <= mem_rsp_data_i;
      q_pc[wr_ptr] <= rsp_pc;
    end
  end
`ifdef IPQ_MISALIGN_CHK_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) misalign_o <= 1'b0;
    else if (redirect_i) misalign_o <= |redirect_pc_i[1:0];
  end
  assign halted = misalign_o;
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: scoreboard bench for instr_prefetch_queue with an in-order memory model
module tb_instr_prefetch_queue;
  logic clk = 1'b0;
  logic rst_i, mem_req_valid_o, mem_req_ready_i, mem_rsp_valid_i, redirect_i;
  logic instr_valid_o, instr_ready_i;
  logic [31:0] mem_req_addr_o, mem_rsp_data_i, redirect_pc_i, instr_o, pc_o;
`ifdef IPQ_MISALIGN_CHK_EN
  logic misalign_o;
`endif
  instr_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o), .pc_o(pc_o)
`ifdef IPQ_MISALIGN_CHK_EN
    , .misalign_o(misalign_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] ins;} exp_t;
  mreq_t mq[$];
  exp_t exq[$];
  int n_cmp = 0, n_err = 0, cyc = 0, lat = 1, hs = 0, pops = 0;
  logic rst_q = 1'b1, redir_q = 1'b0, rdy_q = 1'b0, mrdy_q = 1'b1, arm = 1'b0, both_seen = 1'b0;
  logic first_pend = 1'b0;
  logic [31:0] rpc_q = '0, efpc = '0, first_exp = '0;
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h1357_9BDF;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step();
    logic rsp;
    logic [31:0] a;
    exp_t e;
    @(negedge clk);
    rsp = 1'b0;
    a = '0;
    if (!rst_q && mq.size() > 0 && mq[0].due <= cyc) begin
      rsp = 1'b1;
      a = mq.pop_front().addr;
    end
    if (arm && rsp && mem_req_valid_o && mrdy_q) begin
      redir_q = 1'b1;
      both_seen = 1'b1;
      arm = 1'b0;
    end
    rst_i = rst_q;
    redirect_i = redir_q;
    redirect_pc_i = rpc_q;
    instr_ready_i = rdy_q;
    mem_req_ready_i = mrdy_q;
    mem_rsp_valid_i = rsp;
    mem_rsp_data_i = rsp ? word(a) : 32'h0;
    #1;
    if (rst_q) begin
      mq.delete();
      exq.delete();
      efpc = 32'h0;
      first_pend = 1'b0;
    end else begin
      if (instr_valid_o && instr_ready_i) begin
        pops++;
        if (exq.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
        else begin
          e = exq.pop_front();
          check("pc", pc_o, e.pc);
          check("instr", instr_o, e.ins);
        end
        if (first_pend) begin
          check("first_pc_after_redirect", pc_o, first_exp);
          first_pend = 1'b0;
        end
      end
      if (mem_req_valid_o && mem_req_ready_i) begin
        hs++;
        check("req_addr", mem_req_addr_o, efpc);
        mq.push_back('{addr: mem_req_addr_o, due: cyc + lat});
        if (!redir_q) exq.push_back('{pc: efpc, ins: word(efpc)});
        efpc += 32'd4;
      end
      if (redir_q) begin
        exq.delete();
        efpc = rpc_q & ~32'd3;
        first_exp = efpc;
        first_pend = 1'b1;
      end
    end
    redir_q = 1'b0;
    cyc++;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic redirect(input logic [31:0] pc);
    redir_q = 1'b1;
    rpc_q = pc;
    step();
  endtask
  initial begin
    run(2);
    check("rst_instr_valid", {31'b0, instr_valid_o}, 32'd0);
    check("rst_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    rst_q = 1'b0;
    hs = 0;
    run(12);
    check("stall_handshakes", hs, 32'd4);
    check("stall_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
    rdy_q = 1'b1;
    run(6);
    pops = 0;
    run(20);
    check("throughput", pops, 32'd20);
    lat = 3;
    run(10);
    redirect(32'h100);
    run(20);
    rpc_q = 32'h200;
    arm = 1'b1;
    for (int i = 0; i < 30 && arm; i++) step();
    check("redirect_on_rsp_and_req", {31'b0, both_seen}, 32'd1);
    run(20);
    redirect(32'h300);
    redirect(32'h340);
    run(20);
    redirect(32'hFFFF_FFF0);
    run(20);
    rst_q = 1'b1;
    step();
    check("midrst_instr_valid", {31'b0, instr_valid_o}, 32'd0);
    check("midrst_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
    check("midrst_instr", instr_o, 32'd0);
    check("midrst_pc", pc_o, 32'd0);
    rst_q = 1'b0;
    run(20);
    lat = 2;
    for (int i = 0; i < 300; i++) begin
      rdy_q = 1'($urandom_range(0, 1));
      mrdy_q = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        redir_q = 1'b1;
        rpc_q = 32'($urandom_range(0, 1023)) << 2;
      end
      step();
    end
    rdy_q = 1'b1;
    mrdy_q = 1'b1;
    run(20);
`ifdef IPQ_MISALIGN_CHK_EN
    redirect(32'h102);
    check("misalign_set", {31'b0, misalign_o}, 32'd1);
    hs = 0;
    run(10);
    check("misalign_no_req", hs, 32'd0);
    check("misalign_req_valid", {31'b0, mem_req_valid_o}, 32'd0);
    redirect(32'h200);
    check("misalign_clear", {31'b0, misalign_o}, 32'd0);
    hs = 0;
    run(20);
    check("misalign_resume", {31'b0, hs != 0}, 32'd1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
